// File: rtl/rf_pkg.sv
// Shared definitions for the forwarding register file and its scoreboard.
//   RF_DATA_W / RF_ADDR_W : default register width and address width
//   FWD_ALU / FWD_MEM     : forwarding source indices; lower index = younger
//                           stage = higher priority in the read mux
package rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    localparam int FWD_ALU = 0;
    localparam int FWD_MEM = 1;

endpackage : rf_pkg

// File: rtl/rf_scoreboard.sv
// Pending-destination scoreboard for long-latency ops.
// Ports:
//   clk, reset            : rising-edge clock, async active-low reset
//   issue_en, issue_addr  : long-latency op issued, marks its destination pending
//   wr_en, wr_addr        : writeback, clears the pending bit of its destination
//   pending               : one bit per register, 1 = value not yet produced
//   pend_cnt              : number of pending registers (registered)
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W   = RF_ADDR_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   issue_en,
    input  logic [ADDR_W-1:0]      issue_addr,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    output logic [2**ADDR_W-1:0]   pending,
    output logic [ADDR_W:0]        pend_cnt
);

    localparam int               DEPTH   = 2**ADDR_W;
    localparam logic [ADDR_W:0]  CNT_ONE = (ADDR_W+1)'(1);

    logic               set_hit;
    logic               clr_hit;
    logic               cnt_inc;
    logic               cnt_dec;
    logic [DEPTH-1:0]   pending_nxt;
    logic [ADDR_W:0]    cnt_nxt;

    assign set_hit = issue_en && !(ZERO_REG && issue_addr == '0);
    assign clr_hit = wr_en    && !(ZERO_REG && wr_addr    == '0);

    // The count moves only on real bit transitions: a duplicate issue or a
    // write to a non-pending register leaves it alone, and a clear that is
    // overridden by a same-address issue is not a transition at all.
    assign cnt_inc = set_hit && !pending[issue_addr];
    assign cnt_dec = clr_hit && pending[wr_addr] && !(set_hit && issue_addr == wr_addr);

    // NOTE: every variable driven in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        pending_nxt = pending;
        if (clr_hit) pending_nxt[wr_addr]    = 1'b0;
        // Applied after the clear so a new producer supersedes the old one.
        if (set_hit) pending_nxt[issue_addr] = 1'b1;
    end

    always_comb begin
        cnt_nxt = pend_cnt;
        case ({cnt_inc, cnt_dec})
            2'b10:   cnt_nxt = pend_cnt + CNT_ONE;
            2'b01:   cnt_nxt = pend_cnt - CNT_ONE;
            default: cnt_nxt = pend_cnt;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            pending  <= pending_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

endmodule : rf_scoreboard

// File: rtl/reg_file_fwd_sb.sv
// Decode-stage register file with prioritised forwarding and a scoreboard.
// Ports:
//   clk, reset         : rising-edge clock, async active-low reset
//   rd_req/rd_addr     : per-port read request and address (packed by port)
//   rd_data/rd_valid   : combinational read data and "architecturally current"
//   stall              : some requested operand is still pending
//   wr_en/wr_addr/wr_data : writeback port (1-cycle write, bypassed to reads)
//   fwd_en/fwd_addr/fwd_data : pipeline forwarding sources, index 0 wins
//   issue_en/issue_addr : long-latency op issue, marks destination pending
//   pend_cnt           : number of pending registers
module reg_file_fwd_sb
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int NUM_FWD  = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD-1:0]          rd_req,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_valid,
    output logic                       stall,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [NUM_FWD-1:0]         fwd_en,
    input  logic [NUM_FWD*ADDR_W-1:0]  fwd_addr,
    input  logic [NUM_FWD*DATA_W-1:0]  fwd_data,
    input  logic                       issue_en,
    input  logic [ADDR_W-1:0]          issue_addr,
    output logic [ADDR_W:0]            pend_cnt
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0]  regs [DEPTH];
    logic [DEPTH-1:0]   pending;
    logic [NUM_RD-1:0]  bypass_hit;

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .pending    (pending),
        .pend_cnt   (pend_cnt)
    );

    // NOTE: the array is explicitly reset because software-visible state must
    // read as zero after reset; this forces flops rather than a RAM macro.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
        end else if (wr_en && !(ZERO_REG && wr_addr == '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Per port: array, then writeback bypass, then forwarding sources from
    // oldest to youngest, so later assignments carry the higher priority.
    // The zero register is checked last and overrides every source.
    always_comb begin
        rd_data    = '0;
        bypass_hit = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_data[i*DATA_W +: DATA_W] = regs[rd_addr[i*ADDR_W +: ADDR_W]];
            if (wr_en && wr_addr == rd_addr[i*ADDR_W +: ADDR_W]) begin
                rd_data[i*DATA_W +: DATA_W] = wr_data;
                bypass_hit[i]               = 1'b1;
            end
            for (int j = NUM_FWD-1; j >= 0; j--) begin
                if (fwd_en[j] && fwd_addr[j*ADDR_W +: ADDR_W] == rd_addr[i*ADDR_W +: ADDR_W]) begin
                    rd_data[i*DATA_W +: DATA_W] = fwd_data[j*DATA_W +: DATA_W];
                    bypass_hit[i]               = 1'b1;
                end
            end
            if (ZERO_REG && rd_addr[i*ADDR_W +: ADDR_W] == '0) begin
                rd_data[i*DATA_W +: DATA_W] = '0;
                bypass_hit[i]               = 1'b1;
            end
        end
    end

    always_comb begin
        rd_valid = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_valid[i] = bypass_hit[i] || !pending[rd_addr[i*ADDR_W +: ADDR_W]];
        end
    end

    assign stall = |(rd_req & ~rd_valid);

endmodule : reg_file_fwd_sb

// File: tb/tb_reg_file_fwd_sb.sv
// Self-checking bench for reg_file_fwd_sb with default parameters.
module tb_reg_file_fwd_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NF = 2;

    logic              clk;
    logic              reset;
    logic [NR-1:0]     rd_req;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_valid;
    logic              stall;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [NF-1:0]     fwd_en;
    logic [NF*AW-1:0]  fwd_addr;
    logic [NF*DW-1:0]  fwd_data;
    logic              issue_en;
    logic [AW-1:0]     issue_addr;
    logic [AW:0]       pend_cnt;

    int n_checks = 0;
    int n_errors = 0;

    reg_file_fwd_sb dut (
        .clk        (clk),
        .reset      (reset),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .stall      (stall),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .fwd_en     (fwd_en),
        .fwd_addr   (fwd_addr),
        .fwd_data   (fwd_data),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .pend_cnt   (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_mem  [32];
    bit            m_pend [32];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 32; k++) begin
                m_mem[k]  <= '0;
                m_pend[k] <= 1'b0;
            end
        end else begin
            if (wr_en && wr_addr != 0) m_mem[wr_addr] <= wr_data;
            if (wr_en) m_pend[wr_addr] <= 1'b0;
            if (issue_en && issue_addr != 0) m_pend[issue_addr] <= 1'b1;
        end
    end

    function automatic int model_count();
        int c = 0;
        for (int k = 0; k < 32; k++) c += int'(m_pend[k]);
        return c;
    endfunction

    function automatic void model_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                                       output logic v);
        logic hit;
        hit = 1'b0;
        d   = m_mem[a];
        if (a == 0) begin
            d   = '0;
            hit = 1'b1;
        end else begin
            for (int j = 0; j < NF; j++) begin
                if (!hit && fwd_en[j] && fwd_addr[j*AW +: AW] == a) begin
                    d   = fwd_data[j*DW +: DW];
                    hit = 1'b1;
                end
            end
            if (!hit && wr_en && wr_addr == a) begin
                d   = wr_data;
                hit = 1'b1;
            end
        end
        v = hit || !m_pend[a];
    endfunction

    // Compare every cycle on the falling edge while out of reset.
    always @(negedge clk) begin
        logic [DW-1:0] ed;
        logic          ev;
        logic          es;
        if (reset === 1'b1) begin
            es = 1'b0;
            for (int i = 0; i < NR; i++) begin
                model_read(rd_addr[i*AW +: AW], ed, ev);
                check($sformatf("model rd_data[%0d]", i), 64'(rd_data[i*DW +: DW]), 64'(ed));
                check($sformatf("model rd_valid[%0d]", i), 64'(rd_valid[i]), 64'(ev));
                es = es | (rd_req[i] & ~ev);
            end
            check("model stall", 64'(stall), 64'(es));
            check("model pend_cnt", 64'(pend_cnt), 64'(model_count()));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_req   = '0;
        wr_en    = 1'b0;
        fwd_en   = '0;
        issue_en = 1'b0;
    endtask

    function automatic logic [DW-1:0] port(input int i);
        return rd_data[i*DW +: DW];
    endfunction

    initial begin
        idle();
        reset      = 1'b0;
        rd_addr    = '0;
        wr_addr    = '0;
        wr_data    = '0;
        fwd_addr   = '0;
        fwd_data   = '0;
        issue_addr = '0;
        #1;
        check("reset pend_cnt", 64'(pend_cnt), 64'd0);
        check("reset stall", 64'(stall), 64'd0);
        step(); step();
        @(negedge clk);
        #2 reset = 1'b1;

        // Priority chain on r3
        step(); wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h11;
        step(); idle();
        rd_addr[0 +: AW] = 5'd3;
        wr_en = 1'b1; wr_data = 32'h22;
        fwd_en = 2'b11;
        fwd_addr = {5'd3, 5'd3};
        fwd_data = {32'h33, 32'h44};
        #1 check("prio fwd0", 64'(port(0)), 64'h44);
        fwd_en[0] = 1'b0;
        #1 check("prio fwd1", 64'(port(0)), 64'h33);
        fwd_en[1] = 1'b0;
        #1 check("prio wb bypass", 64'(port(0)), 64'h22);
        step(); idle();
        #1 check("prio array", 64'(port(0)), 64'h22);

        // Zero register
        step(); idle();
        rd_req = 2'b01; rd_addr[0 +: AW] = 5'd0;
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
        fwd_en = 2'b01; fwd_addr[0 +: AW] = 5'd0; fwd_data[0 +: DW] = 32'h5;
        issue_en = 1'b1; issue_addr = 5'd0;
        #1 check("zero rd_data", 64'(port(0)), 64'd0);
        check("zero rd_valid", 64'(rd_valid[0]), 64'd1);
        step(); idle(); rd_req = 2'b01;
        #1 check("zero pend_cnt", 64'(pend_cnt), 64'd0);
        check("zero after write", 64'(port(0)), 64'd0);

        // Load-use
        step(); idle(); issue_en = 1'b1; issue_addr = 5'd7;
        step(); idle(); rd_req = 2'b01; rd_addr[0 +: AW] = 5'd7;
        #1 check("load-use valid", 64'(rd_valid[0]), 64'd0);
        check("load-use stall", 64'(stall), 64'd1);
        check("load-use cnt", 64'(pend_cnt), 64'd1);
        step(); wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h99;
        #1 check("load-use wb data", 64'(port(0)), 64'h99);
        check("load-use wb stall", 64'(stall), 64'd0);
        step(); idle();
        #1 check("load-use cnt clr", 64'(pend_cnt), 64'd0);

        // Set wins over clear on the same edge
        step(); idle(); issue_en = 1'b1; issue_addr = 5'd9;
        step(); idle();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hAB;
        issue_en = 1'b1; issue_addr = 5'd9;
        step(); idle(); rd_req = 2'b10; rd_addr[AW +: AW] = 5'd9;
        #1 check("set-wins cnt", 64'(pend_cnt), 64'd1);
        check("set-wins valid", 64'(rd_valid[1]), 64'd0);
        check("set-wins stall", 64'(stall), 64'd1);
        check("set-wins array", 64'(port(1)), 64'hAB);
        // Issue r2 while writing back r9: one set, one clear, count unchanged
        step(); idle();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hAC;
        issue_en = 1'b1; issue_addr = 5'd2;
        step(); idle();
        #1 check("swap cnt", 64'(pend_cnt), 64'd1);
        step(); wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h2;
        step(); idle();
        #1 check("swap cnt clr", 64'(pend_cnt), 64'd0);

        // Fill and drain the scoreboard; reads are not requested
        rd_addr = {5'd4, 5'd1};
        for (int k = 1; k < 32; k++) begin
            step(); idle(); issue_en = 1'b1; issue_addr = AW'(k);
        end
        step(); idle(); issue_en = 1'b1; issue_addr = 5'd5;
        #1 check("fill cnt", 64'(pend_cnt), 64'd31);
        step(); idle();
        #1 check("dup cnt", 64'(pend_cnt), 64'd31);
        check("fill no stall", 64'(stall), 64'd0);
        for (int k = 1; k < 32; k++) begin
            step(); idle(); wr_en = 1'b1; wr_addr = AW'(k); wr_data = 32'(k * 3);
        end
        step(); idle();
        #1 check("drain cnt", 64'(pend_cnt), 64'd0);
        step(); idle(); wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h7;
        step(); idle(); rd_addr[0 +: AW] = 5'd31;
        #1 check("idle write cnt", 64'(pend_cnt), 64'd0);
        check("drain r31", 64'(port(0)), 64'd93);

        // Asynchronous reset mid-operation
        step(); idle(); wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD;
        issue_en = 1'b1; issue_addr = 5'd6;
        step(); idle(); rd_req = 2'b11; rd_addr = {5'd6, 5'd5};
        #1 check("pre-reset r5", 64'(port(0)), 64'hDEAD);
        check("pre-reset stall", 64'(stall), 64'd1);
        #2 reset = 1'b0;
        #1 check("reset r5", 64'(port(0)), 64'd0);
        check("reset cnt", 64'(pend_cnt), 64'd0);
        check("reset stall mid", 64'(stall), 64'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        step(); step();
        #1 check("post-reset valid", 64'(rd_valid), 64'd3);

        step();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_reg_file_fwd_sb
